// File: rtl/timer_ctrl.sv
// Sequencing controller for one `timer` instance: start/stop/clear handling,
// prescaled enable strobes, completion pulse and shadow-count mismatch check.
// Optional build macro TIMER_CTRL_AUTORELOAD_EN: DONE lasts one cycle and reloads tgt_q.
module timer_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] tmr_data,
  output logic             tmr_enable,
  output logic             tmr_clear,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state,
  output logic             err
);

  localparam int unsigned PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             tmr_enable_d, tmr_clear_d, done_d, busy_d, err_d;
  logic             start_req, advance, last_strobe, mismatch;

  assign state = 2'(state_q);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      tmr_enable <= 1'b0;
      tmr_clear  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      tmr_enable <= tmr_enable_d;
      tmr_clear  <= tmr_clear_d;
      done       <= done_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

  // Next state, shadow count, prescaler and output decode
  always_comb begin
    start_req   = start & ~stop;
    last_strobe = tmr_enable && (WIDTH'(cnt_q + 1'b1) == tgt_q);
    mismatch    = (state_q != IDLE) && !tmr_clear && (tmr_data != cnt_q);

    state_d     = state_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q + WIDTH'(tmr_enable);
    pc_d        = pc_q;
    tmr_clear_d = 1'b0;
    done_d      = 1'b0;
    err_d       = err | mismatch;
    advance     = 1'b0;

    if (clear) begin
      state_d     = IDLE;
      tmr_clear_d = 1'b1;
      cnt_d       = '0;
      pc_d        = '0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_req) begin
            tgt_d       = target;
            tmr_clear_d = 1'b1;
            cnt_d       = '0;
            pc_d        = '0;
            if (target == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
`ifdef TIMER_CTRL_AUTORELOAD_EN
          // The DONE entry cycle already cleared the timer; it doubles as the clear cycle
          else if (state_q == DONE && done && !stop) begin
            if (tgt_q == '0) begin
              tmr_clear_d = 1'b1;
              done_d      = 1'b1;
            end else begin
              state_d = RUN;
              advance = 1'b1;
            end
          end
`endif
        end
        RUN: begin
          // Completion outranks a coincident stop so the count never overshoots
          if (last_strobe) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
            tmr_clear_d = 1'b1;
            cnt_d       = '0;
            pc_d        = '0;
`endif
          end else if (stop) begin
            state_d = PAUSE;
          end else begin
            advance = 1'b1;
          end
        end
        PAUSE: begin
          if (start_req) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Prescaler phase is held while paused so resuming keeps the strobe cadence
    if (advance) begin
      pc_d = (pc_q == PC_LAST) ? '0 : PCW'(pc_q + 1'b1);
    end
    tmr_enable_d = advance && (pc_q == PC_LAST);
    busy_d       = (state_d == RUN) || (state_d == PAUSE);
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; PRESCALE=1 and PRESCALE=3 instances each drive a behavioural timer.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, clear;
  logic [3:0] target;

  logic       en1, clr1, done1, busy1, err1;
  logic [1:0] st1;
  logic       en3, clr3, done3, busy3, err3;
  logic [1:0] st3;

  logic [3:0] tdata1, tdata3, data1;
  logic       force_en;
  logic [3:0] force_val;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .target(target), .tmr_data(data1), .tmr_enable(en1), .tmr_clear(clr1),
    .done(done1), .busy(busy1), .state(st1), .err(err1)
  );

  timer_ctrl #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .target(target), .tmr_data(tdata3), .tmr_enable(en3), .tmr_clear(clr3),
    .done(done3), .busy(busy3), .state(st3), .err(err3)
  );

  assign data1 = force_en ? force_val : tdata1;

  // Behavioural timers: synchronous clear, count on enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata1 <= '0;
      tdata3 <= '0;
    end else begin
      if (clr1) tdata1 <= '0;
      else if (en1) tdata1 <= tdata1 + 4'd1;
      if (clr3) tdata3 <= '0;
      else if (en3) tdata3 <= tdata3 + 4'd1;
    end
  end

  task automatic go_idle();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({clr1, en1, done1, busy1, st1, err1} !== 7'b0) begin
      errs++;
      $display("FAIL reset_p1 got %b want %b", {clr1, en1, done1, busy1, st1, err1}, 7'b0);
    end
    vecs++;
    if ({clr3, en3, done3, busy3, st3, err3} !== 7'b0) begin
      errs++;
      $display("FAIL reset_p3 got %b want %b", {clr3, en3, done3, busy3, st3, err3}, 7'b0);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_run_p1();
    logic [5:0] exp;
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd5;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      exp = {c == 1, c >= 2 && c <= 6, c == 7, c <= 6, (c <= 6) ? 2'd1 : 2'd3};
      vecs++;
      if ({clr1, en1, done1, busy1, st1} !== exp) begin
        errs++;
        $display("FAIL run_p1 c%0d got %b want %b", c, {clr1, en1, done1, busy1, st1}, exp);
      end
      if (c == 7) begin
        vecs++;
        if ({tdata1, err1} !== {4'd5, 1'b0}) begin
          errs++;
          $display("FAIL run_p1_data got %h/%b want 5/0", tdata1, err1);
        end
      end
    end
  endtask

  task automatic test_prescale3();
    logic [5:0] exp;
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd2;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      exp = {c == 1, c == 4 || c == 7, c == 8, c <= 7, (c <= 7) ? 2'd1 : 2'd3};
      vecs++;
      if ({clr3, en3, done3, busy3, st3} !== exp) begin
        errs++;
        $display("FAIL run_p3 c%0d got %b want %b", c, {clr3, en3, done3, busy3, st3}, exp);
      end
    end
    vecs++;
    if ({tdata3, err3} !== {4'd2, 1'b0}) begin
      errs++;
      $display("FAIL run_p3_data got %h/%b want 2/0", tdata3, err3);
    end
  endtask

  task automatic test_pause_resume();
    logic [5:0] exp;
    logic [1:0] est;
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd10;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c <= 4 || (c >= 10 && c <= 16)) est = 2'd1;
      else if (c <= 9) est = 2'd2;
      else est = 2'd3;
      exp = {c == 1, (c >= 2 && c <= 4) || (c >= 10 && c <= 16), c == 17, c <= 16, est};
      vecs++;
      if ({clr1, en1, done1, busy1, st1} !== exp) begin
        errs++;
        $display("FAIL pause_resume c%0d got %b want %b", c, {clr1, en1, done1, busy1, st1}, exp);
      end
      if (c == 17) begin
        vecs++;
        if ({tdata1, err1} !== {4'd10, 1'b0}) begin
          errs++;
          $display("FAIL pause_resume_data got %h/%b want a/0", tdata1, err1);
        end
      end
      start = (c == 9);
      stop  = (c == 4);
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_priority();
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd10;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) begin
        vecs++;
        if ({en1, busy1, st1} !== {1'b0, 1'b1, 2'd2}) begin
          errs++;
          $display("FAIL start_stop_pause got %b want %b", {en1, busy1, st1}, 4'b0110);
        end
      end
      if (c == 6) begin
        vecs++;
        if ({clr1, en1, busy1, st1} !== 5'b10000) begin
          errs++;
          $display("FAIL clear_wins got %b want %b", {clr1, en1, busy1, st1}, 5'b10000);
        end
      end
      if (c == 7) begin
        vecs++;
        if ({clr1, st1, tdata1} !== 7'b0) begin
          errs++;
          $display("FAIL clear_one_cycle got %b want %b", {clr1, st1, tdata1}, 7'b0);
        end
      end
      if (c == 8) begin
        vecs++;
        if ({clr1, busy1, st1} !== 4'b0) begin
          errs++;
          $display("FAIL idle_start_stop_ignored got %b want %b", {clr1, busy1, st1}, 4'b0);
        end
      end
      start = (c == 3) || (c == 7);
      stop  = (c == 3) || (c == 5) || (c == 7);
      clear = (c == 5);
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic test_zero_and_err();
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vecs++;
        if ({clr1, en1, done1, busy1, st1} !== 6'b101011) begin
          errs++;
          $display("FAIL zero_target got %b want %b", {clr1, en1, done1, busy1, st1}, 6'b101011);
        end
      end
      if (c == 2) begin
        vecs++;
        if ({clr1, en1, done1, busy1, st1} !== 6'b000011) begin
          errs++;
          $display("FAIL zero_target_hold got %b want %b", {clr1, en1, done1, busy1, st1}, 6'b000011);
        end
      end
      if (c == 6) begin
        vecs++;
        if ({st1, tdata1, err1} !== {2'd2, 4'd2, 1'b0}) begin
          errs++;
          $display("FAIL err_pre got %b want %b", {st1, tdata1, err1}, {2'd2, 4'd2, 1'b0});
        end
      end
      if (c >= 7 && c <= 8) begin
        vecs++;
        if (err1 !== 1'b1) begin
          errs++;
          $display("FAIL err_sticky c%0d got %b want 1", c, err1);
        end
      end
      if (c == 9) begin
        vecs++;
        if ({err1, st1} !== 3'b0) begin
          errs++;
          $display("FAIL err_clear got %b want 000", {err1, st1});
        end
      end
      start     = (c == 2);
      target    = 4'd5;
      stop      = (c == 5);
      force_en  = (c == 6);
      force_val = 4'd3;
      clear     = (c == 8);
    end
    start = 1'b0; stop = 1'b0; clear = 1'b0; force_en = 1'b0;
  endtask

  task automatic test_async_reset();
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd10;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({clr1, en1, done1, busy1, st1, err1, clr3, en3, done3, busy3, st3, err3} !== 14'b0) begin
      errs++;
      $display("FAIL async_reset got %b want 0", {clr1, en1, done1, busy1, st1, err1, clr3, en3, done3, busy3, st3, err3});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({clr1, en1, done1, busy1, st1, err1} !== 7'b0) begin
      errs++;
      $display("FAIL post_reset_idle got %b want 0", {clr1, en1, done1, busy1, st1, err1});
    end
  endtask

  task automatic test_autoreload();
    logic [5:0] exp;
    logic       dc;
    go_idle();
    @(negedge clk); start = 1'b1; target = 4'd3;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      dc  = (c == 5) || (c == 9);
      exp = {c == 1 || dc, (c >= 2 && c <= 4) || (c >= 6 && c <= 8) || c == 10, dc, !dc, dc ? 2'd3 : 2'd1};
      vecs++;
      if ({clr1, en1, done1, busy1, st1} !== exp || err1 !== 1'b0) begin
        errs++;
        $display("FAIL autoreload c%0d got %b/%b want %b/0", c, {clr1, en1, done1, busy1, st1}, err1, exp);
      end
    end
    #2 rst = 1'b0;
    #1;
    vecs++;
    if ({clr1, en1, done1, busy1, st1, err1} !== 7'b0) begin
      errs++;
      $display("FAIL autoreload_reset got %b want 0", {clr1, en1, done1, busy1, st1, err1});
    end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; target = 4'd0;
    force_en = 1'b0; force_val = 4'd0;
    test_reset();
`ifdef TIMER_CTRL_AUTORELOAD_EN
    test_autoreload();
`else
    test_run_p1();
    test_prescale3();
    test_pause_resume();
    test_priority();
    test_zero_and_err();
    test_async_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
